// File: rtl/exu_agu.sv
// rtl/exu_agu.sv - load/store address generation and memory request sequencing
module exu_agu #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                agu_i_valid,
  output logic                agu_o_ready,
  input  logic                agu_i_load,
  input  logic                agu_i_store,
  input  logic                agu_i_usign,
  input  logic [1:0]          agu_i_size,
  input  logic [XLEN-1:0]     agu_i_rs1,
  input  logic [XLEN-1:0]     agu_i_rs2,
  input  logic [XLEN-1:0]     agu_i_imm,
  input  logic [4:0]          agu_i_rd_idx,
  input  logic                agu_i_flush,
  output logic                agu_o_cmd_enable,
  output logic                agu_o_cmd_read,
  output logic                agu_o_cmd_write,
  output logic                agu_o_cmd_usign,
  output logic [1:0]          agu_o_cmd_size,
  output logic [PC_SIZE-1:0]  agu_o_cmd_addr,
  output logic [XLEN-1:0]     agu_o_cmd_wdata,
  output logic [XLEN/8-1:0]   agu_o_cmd_wmask,
  output logic                agu_o_cmd_misalgn,
  output logic                agu_o_mem_valid,
  input  logic                agu_i_mem_ready,
  input  logic [XLEN-1:0]     agu_i_lsu_wdata,
  input  logic                agu_i_lsu_err,
  output logic                agu_o_wbck_valid,
  input  logic                agu_i_wbck_ready,
  output logic [XLEN-1:0]     agu_o_wbck_wdata,
  output logic [4:0]          agu_o_wbck_rd_idx,
  output logic                agu_o_wbck_rdwen,
  output logic                agu_o_wbck_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WBCK = 2'd2} state_e;

  state_e state_q, state_d;
  logic   kill_q, kill_d;

  logic [PC_SIZE-1:0] addr;
  logic               misalgn;
  logic [3:0]         mask;
  logic [31:0]        sdata;
  logic               accept;
  logic               mem_hs;

  // Effective address wraps modulo 2^PC_SIZE; the carry is simply dropped.
  assign addr = agu_i_rs1[PC_SIZE-1:0] + agu_i_imm[PC_SIZE-1:0];

  assign agu_o_ready      = (state_q == IDLE);
  assign agu_o_mem_valid  = (state_q == REQ);
  // A flush in WBCK kills the result in the same cycle, not only from the next one.
  assign agu_o_wbck_valid = (state_q == WBCK) & ~kill_q & ~agu_i_flush;

  assign accept = agu_i_valid & agu_o_ready;
  assign mem_hs = agu_o_mem_valid & agu_i_mem_ready;

  // Alignment check, byte mask and lane-replicated store data for the offered op.
  always_comb begin
    misalgn = 1'b0;
    mask    = 4'b0000;
    sdata   = agu_i_rs2[31:0];
    case (agu_i_size)
      2'b00: begin
        mask  = 4'b0001 << addr[1:0];
        sdata = {4{agu_i_rs2[7:0]}};
      end
      2'b01: begin
        misalgn = addr[0];
        mask    = 4'b0011 << {addr[1], 1'b0};
        sdata   = {2{agu_i_rs2[15:0]}};
      end
      2'b10: begin
        misalgn = (addr[1:0] != 2'b00);
        mask    = 4'b1111;
      end
      default: misalgn = 1'b1;
    endcase
    if (!agu_i_store) begin
      mask  = 4'b0000;
      sdata = 32'h0;
    end
  end

  // Next-state and kill-flag logic.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (agu_i_valid) state_d = misalgn ? WBCK : REQ;
      end
      REQ: begin
        if (agu_i_flush) kill_d = 1'b1;
        if (agu_i_mem_ready) state_d = WBCK;
      end
      WBCK: begin
        if ((agu_o_wbck_valid & agu_i_wbck_ready) | kill_q | agu_i_flush) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // State and kill flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Command bundle is captured at accept and held until the memory handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      agu_o_cmd_enable  <= 1'b0;
      agu_o_cmd_read    <= 1'b0;
      agu_o_cmd_write   <= 1'b0;
      agu_o_cmd_usign   <= 1'b0;
      agu_o_cmd_size    <= 2'b00;
      agu_o_cmd_addr    <= '0;
      agu_o_cmd_wdata   <= '0;
      agu_o_cmd_wmask   <= '0;
      agu_o_cmd_misalgn <= 1'b0;
    end else if (accept) begin
      agu_o_cmd_enable  <= ~misalgn;
      agu_o_cmd_read    <= agu_i_load;
      agu_o_cmd_write   <= agu_i_store;
      agu_o_cmd_usign   <= agu_i_usign;
      agu_o_cmd_size    <= agu_i_size;
      agu_o_cmd_addr    <= addr;
      agu_o_cmd_wdata   <= XLEN'(sdata);
      agu_o_cmd_wmask   <= (XLEN/8)'(mask);
      agu_o_cmd_misalgn <= misalgn;
    end
  end

  // Write-back register: fault address on a misaligned accept, LSU result on the memory handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      agu_o_wbck_wdata  <= '0;
      agu_o_wbck_rd_idx <= 5'd0;
      agu_o_wbck_rdwen  <= 1'b0;
      agu_o_wbck_err    <= 1'b0;
    end else if (accept) begin
      agu_o_wbck_rd_idx <= agu_i_rd_idx;
      if (misalgn) begin
        agu_o_wbck_wdata <= XLEN'(addr);
        agu_o_wbck_rdwen <= 1'b0;
        agu_o_wbck_err   <= 1'b1;
      end
    end else if (mem_hs) begin
      agu_o_wbck_wdata <= agu_i_lsu_wdata;
      agu_o_wbck_rdwen <= agu_o_cmd_read & ~agu_i_lsu_err;
      agu_o_wbck_err   <= agu_i_lsu_err;
    end
  end

endmodule

// File: tb/tb_exu_agu.sv
// tb/tb_exu_agu.sv - directed scoreboard bench for exu_agu
module tb_exu_agu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        agu_i_valid = 1'b0, agu_o_ready;
  logic        agu_i_load = 1'b0, agu_i_store = 1'b0, agu_i_usign = 1'b0;
  logic [1:0]  agu_i_size = 2'b00;
  logic [31:0] agu_i_rs1 = '0, agu_i_rs2 = '0, agu_i_imm = '0;
  logic [4:0]  agu_i_rd_idx = '0;
  logic        agu_i_flush = 1'b0;
  logic        agu_o_cmd_enable, agu_o_cmd_read, agu_o_cmd_write, agu_o_cmd_usign;
  logic [1:0]  agu_o_cmd_size;
  logic [31:0] agu_o_cmd_addr, agu_o_cmd_wdata;
  logic [3:0]  agu_o_cmd_wmask;
  logic        agu_o_cmd_misalgn, agu_o_mem_valid;
  logic        agu_i_mem_ready = 1'b0;
  logic [31:0] agu_i_lsu_wdata = '0;
  logic        agu_i_lsu_err = 1'b0;
  logic        agu_o_wbck_valid;
  logic        agu_i_wbck_ready = 1'b0;
  logic [31:0] agu_o_wbck_wdata;
  logic [4:0]  agu_o_wbck_rd_idx;
  logic        agu_o_wbck_rdwen, agu_o_wbck_err;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rdwen;
    logic        err;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  exu_agu #(.XLEN(32), .PC_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .agu_i_valid(agu_i_valid), .agu_o_ready(agu_o_ready),
    .agu_i_load(agu_i_load), .agu_i_store(agu_i_store), .agu_i_usign(agu_i_usign),
    .agu_i_size(agu_i_size), .agu_i_rs1(agu_i_rs1), .agu_i_rs2(agu_i_rs2),
    .agu_i_imm(agu_i_imm), .agu_i_rd_idx(agu_i_rd_idx), .agu_i_flush(agu_i_flush),
    .agu_o_cmd_enable(agu_o_cmd_enable), .agu_o_cmd_read(agu_o_cmd_read),
    .agu_o_cmd_write(agu_o_cmd_write), .agu_o_cmd_usign(agu_o_cmd_usign),
    .agu_o_cmd_size(agu_o_cmd_size), .agu_o_cmd_addr(agu_o_cmd_addr),
    .agu_o_cmd_wdata(agu_o_cmd_wdata), .agu_o_cmd_wmask(agu_o_cmd_wmask),
    .agu_o_cmd_misalgn(agu_o_cmd_misalgn), .agu_o_mem_valid(agu_o_mem_valid),
    .agu_i_mem_ready(agu_i_mem_ready), .agu_i_lsu_wdata(agu_i_lsu_wdata),
    .agu_i_lsu_err(agu_i_lsu_err), .agu_o_wbck_valid(agu_o_wbck_valid),
    .agu_i_wbck_ready(agu_i_wbck_ready), .agu_o_wbck_wdata(agu_o_wbck_wdata),
    .agu_o_wbck_rd_idx(agu_o_wbck_rd_idx), .agu_o_wbck_rdwen(agu_o_wbck_rdwen),
    .agu_o_wbck_err(agu_o_wbck_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    wb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed wbck with empty scoreboard expected none", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".wdata"}, agu_o_wbck_wdata, e.wdata);
      chk({tag, ".rd"},    32'(agu_o_wbck_rd_idx), 32'(e.rd));
      chk({tag, ".rdwen"}, 32'(agu_o_wbck_rdwen), 32'(e.rdwen));
      chk({tag, ".err"},   32'(agu_o_wbck_err), 32'(e.err));
    end
  endtask

  // One complete op; called at #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic ld, input logic [1:0] sz,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [31:0] lsu_d, input logic lsu_e,
                        input int mstall, input int wstall, input logic fl,
                        input logic [31:0] e_addr, input logic [3:0] e_mask,
                        input logic [31:0] e_cwd, input logic e_mis);
    wb_t e;
    chk({tag, ".ready0"}, 32'(agu_o_ready), 32'd1);
    agu_i_valid = 1'b1; agu_i_load = ld; agu_i_store = ~ld; agu_i_size = sz;
    agu_i_rs1 = rs1; agu_i_rs2 = rs2; agu_i_imm = imm; agu_i_rd_idx = rd;
    e.rd = rd;
    if (e_mis) begin
      e.wdata = e_addr; e.rdwen = 1'b0; e.err = 1'b1;
    end else begin
      e.wdata = lsu_d; e.rdwen = ld & ~lsu_e; e.err = lsu_e;
    end
    if (!fl) sb_q.push_back(e);
    tick();
    agu_i_valid = 1'b0; agu_i_rs1 = 32'h5A5A5A5A; agu_i_rs2 = 32'hA5A5A5A5;
    if (e_mis) begin
      chk({tag, ".mem_valid"}, 32'(agu_o_mem_valid), 32'd0);
      chk({tag, ".wbck_valid"}, 32'(agu_o_wbck_valid), 32'd1);
      pop_chk(tag);
    end else begin
      chk({tag, ".mem_valid"}, 32'(agu_o_mem_valid), 32'd1);
      chk({tag, ".cmd_addr"},  agu_o_cmd_addr, e_addr);
      chk({tag, ".cmd_wmask"}, 32'(agu_o_cmd_wmask), 32'(e_mask));
      chk({tag, ".cmd_wdata"}, agu_o_cmd_wdata, e_cwd);
      chk({tag, ".cmd_rw"},    32'({agu_o_cmd_enable, agu_o_cmd_read, agu_o_cmd_write}),
          32'({1'b1, ld, ~ld}));
      for (int i = 0; i < mstall; i++) begin
        tick();
        chk({tag, ".stall_mem_valid"}, 32'(agu_o_mem_valid), 32'd1);
        chk({tag, ".stall_cmd_addr"},  agu_o_cmd_addr, e_addr);
        chk({tag, ".stall_cmd_wdata"}, agu_o_cmd_wdata, e_cwd);
        chk({tag, ".stall_ready"},     32'(agu_o_ready), 32'd0);
      end
      agu_i_mem_ready = 1'b1; agu_i_lsu_wdata = lsu_d; agu_i_lsu_err = lsu_e; agu_i_flush = fl;
      tick();
      agu_i_mem_ready = 1'b0; agu_i_lsu_wdata = 32'h13579BDF; agu_i_lsu_err = 1'b0;
      agu_i_flush = 1'b0;
      chk({tag, ".mem_valid_off"}, 32'(agu_o_mem_valid), 32'd0);
      if (fl) begin
        chk({tag, ".killed_wbck"}, 32'(agu_o_wbck_valid), 32'd0);
      end else begin
        for (int i = 0; i < wstall; i++) begin
          chk({tag, ".stall_wbck_valid"}, 32'(agu_o_wbck_valid), 32'd1);
          chk({tag, ".stall_wbck_wdata"}, agu_o_wbck_wdata, e.wdata);
          chk({tag, ".stall_ready"},      32'(agu_o_ready), 32'd0);
          tick();
        end
        chk({tag, ".wbck_valid"}, 32'(agu_o_wbck_valid), 32'd1);
        pop_chk(tag);
      end
    end
    agu_i_wbck_ready = 1'b1;
    tick();
    agu_i_wbck_ready = 1'b0;
    chk({tag, ".retired"}, 32'({agu_o_ready, agu_o_wbck_valid}), 32'b10);
  endtask

  initial begin
    tick();
    chk("rst.ready",      32'(agu_o_ready), 32'd1);
    chk("rst.mem_valid",  32'(agu_o_mem_valid), 32'd0);
    chk("rst.wbck_valid", 32'(agu_o_wbck_valid), 32'd0);
    chk("rst.cmd_addr",   agu_o_cmd_addr, 32'd0);
    chk("rst.wbck_wdata", agu_o_wbck_wdata, 32'd0);
    rst = 1'b0;
    tick();

    //     tag    ld   sz     rs1           rs2           imm       rd   lsu_d         e  ms ws fl  addr          mask     cwdata        mis
    run_op("lw",  1, 2'b10, 32'h00001000, 32'h0,        32'h8,    5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 32'h00001008, 4'b0000, 32'h0,        0);
    run_op("sb",  0, 2'b00, 32'h00002001, 32'h12345678, 32'h2,    5'd6, 32'h0,        0, 0, 0, 0, 32'h00002003, 4'b1000, 32'h78787878, 0);
    run_op("lh_mis", 1, 2'b01, 32'h00003000, 32'h0,     32'h1,    5'd7, 32'h0,        0, 0, 0, 0, 32'h00003001, 4'b0000, 32'h0,        1);
    run_op("sz11", 1, 2'b11, 32'h00004000, 32'h0,       32'h0,    5'd8, 32'h0,        0, 0, 0, 0, 32'h00004000, 4'b0000, 32'h0,        1);
    run_op("bp",  1, 2'b10, 32'h00000100, 32'h0,        32'h20,   5'd9, 32'hCAFEF00D, 0, 5, 3, 0, 32'h00000120, 4'b0000, 32'h0,        0);
    run_op("flush", 1, 2'b10, 32'h00000500, 32'h0,      32'h0,    5'd10, 32'h11111111, 0, 1, 0, 1, 32'h00000500, 4'b0000, 32'h0,      0);
    run_op("sw_err", 0, 2'b10, 32'h00000600, 32'hA5A5A5A5, 32'h4, 5'd11, 32'h00000000, 1, 0, 0, 0, 32'h00000604, 4'b1111, 32'hA5A5A5A5, 0);
    run_op("wrap", 1, 2'b10, 32'hFFFFFFFC, 32'h0,       32'h8,    5'd12, 32'h0BADF00D, 0, 0, 0, 0, 32'h00000004, 4'b0000, 32'h0,       0);
    run_op("sh",  0, 2'b01, 32'h00000010, 32'hBEEF1234, 32'h2,    5'd13, 32'h0,        0, 0, 1, 0, 32'h00000012, 4'b1100, 32'h12341234, 0);

    // Reset asserted while a request is outstanding
    agu_i_valid = 1'b1; agu_i_load = 1'b1; agu_i_store = 1'b0; agu_i_size = 2'b10;
    agu_i_rs1 = 32'h700; agu_i_imm = 32'h0;
    tick();
    agu_i_valid = 1'b0;
    chk("rstreq.mem_valid_before", 32'(agu_o_mem_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq.mem_valid_async", 32'(agu_o_mem_valid), 32'd0);
    chk("rstreq.cmd_addr",        agu_o_cmd_addr, 32'd0);
    chk("rstreq.ready",           32'(agu_o_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("rstreq.idle_after", 32'({agu_o_ready, agu_o_mem_valid, agu_o_wbck_valid}), 32'b100);
    chk("sb.empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
